// File: rtl/dft_input_reorder_if.sv
// Handshake bundle for dft_input_reorder: sample load side and butterfly-pair drain side.
// slave is the reorder block's view; master is the driving/consuming environment.
interface dft_input_reorder_if #(
    parameter int LOG2_N  = 3,
    parameter int WORD_SZ = 32
);
    logic [WORD_SZ-1:0] i_sample;
    logic               i_sample_valid;
    logic               o_sample_ready;
    logic [WORD_SZ-1:0] o_A;
    logic [WORD_SZ-1:0] o_B;
    logic [LOG2_N-2:0]  o_pair_idx;
    logic               o_pair_valid;
    logic               i_pair_ready;
    logic               o_frame_done;

    modport slave (
        input  i_sample, i_sample_valid, i_pair_ready,
        output o_sample_ready, o_A, o_B, o_pair_idx, o_pair_valid, o_frame_done
    );

    modport master (
        output i_sample, i_sample_valid, i_pair_ready,
        input  o_sample_ready, o_A, o_B, o_pair_idx, o_pair_valid, o_frame_done
    );
endinterface

// File: rtl/dft_input_reorder.sv
// Frame buffer ahead of the first radix-2 DIT stage: loads N_POINTS samples at
// bit-reversed addresses, then drains them as adjacent (A, B) butterfly pairs.
module dft_input_reorder #(
    parameter int N_POINTS = 8,
    parameter int LOG2_N   = 3,
    parameter int WORD_SZ  = 32
) (
    input logic                i_clk,
    input logic                i_rst_n,
    dft_input_reorder_if.slave bus
);
    localparam int PW = LOG2_N - 1;

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [WORD_SZ-1:0]  mem [N_POINTS];
    logic [LOG2_N-1:0]   wr_cnt;
    logic [PW-1:0]       rd_cnt;
    logic                frame_done;
    logic                sample_acc, pair_acc, last_wr, last_rd;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) r[i] = a[LOG2_N-1-i];
        return r;
    endfunction

    assign sample_acc = (state == LOAD) && bus.i_sample_valid;
    assign pair_acc   = (state == DRAIN) && bus.i_pair_ready;
    assign last_wr    = (wr_cnt == LOG2_N'(N_POINTS - 1));
    assign last_rd    = (rd_cnt == {PW{1'b1}});

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (sample_acc && last_wr) state_nxt = DRAIN;
            DRAIN:   if (pair_acc && last_rd)   state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= LOAD;
        else          state <= state_nxt;
    end

    // Counters wrap naturally because N_POINTS is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (sample_acc) wr_cnt <= wr_cnt + LOG2_N'(1);
            if (pair_acc)   rd_cnt <= rd_cnt + PW'(1);
            frame_done <= pair_acc && last_rd;
        end
    end

    // Storage is deliberately not reset; a new frame simply overwrites it.
    always_ff @(posedge i_clk) begin
        if (sample_acc) mem[bitrev(wr_cnt)] <= bus.i_sample;
    end

    always_comb begin
        bus.o_sample_ready = (state == LOAD);
        bus.o_pair_valid   = (state == DRAIN);
        bus.o_frame_done   = frame_done;
        bus.o_A            = '0;
        bus.o_B            = '0;
        bus.o_pair_idx     = '0;
        if (state == DRAIN) begin
            bus.o_A        = mem[{rd_cnt, 1'b0}];
            bus.o_B        = mem[{rd_cnt, 1'b1}];
            bus.o_pair_idx = rd_cnt;
        end
    end
endmodule

// File: tb/tb_dft_input_reorder.sv
// Bench for dft_input_reorder: directed vector table, reset corners and random
// frames checked against an even/odd decimation model of the DIT input order.
module tb_dft_input_reorder;
    localparam int N = 8;
    localparam int L = 3;
    localparam int P = N / 2;

    typedef logic [31:0] frame_t [N];
    typedef logic [P-1:0][31:0] pairs_t;

    typedef struct {
        logic [31:0] base;
        bit          gap;
        int          stall_at;
        int          stall_len;
        bit          b2b;
        pairs_t      exp_a;
        pairs_t      exp_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   pending_done = 0;
    int   ord [N];
    int   tmp [N];

    dft_input_reorder_if #(.LOG2_N(L), .WORD_SZ(32)) bus ();

    dft_input_reorder #(.N_POINTS(N), .LOG2_N(L), .WORD_SZ(32)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // DIT input order: repeatedly split every block into even then odd positions.
    task automatic build_order();
        for (int i = 0; i < N; i++) ord[i] = i;
        for (int sz = N; sz >= 4; sz /= 2)
            for (int b = 0; b < N; b += sz) begin
                for (int j = 0; j < sz; j += 2) begin
                    tmp[j/2]        = ord[b+j];
                    tmp[sz/2 + j/2] = ord[b+j+1];
                end
                for (int j = 0; j < sz; j++) ord[b+j] = tmp[j];
            end
    endtask

    task automatic model(input frame_t xs, output pairs_t ea, output pairs_t eb);
        for (int p = 0; p < P; p++) begin
            ea[p] = xs[ord[2*p]];
            eb[p] = xs[ord[2*p+1]];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.o_sample_ready), 32'd1);
        chk({tag, "_pvalid"}, 32'(bus.o_pair_valid), 32'd0);
        chk({tag, "_A"}, bus.o_A, 32'd0);
        chk({tag, "_B"}, bus.o_B, 32'd0);
        chk({tag, "_idx"}, 32'(bus.o_pair_idx), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_frame_done), 32'd0);
    endtask

    // Entered and left at posedge+1.
    task automatic load_frame(input frame_t xs, input bit gap, input bit exp_done_first);
        for (int k = 0; k < N; k++) begin
            bus.i_sample = xs[k];
            bus.i_sample_valid = 1'b1;
            @(negedge clk);
            chk("load_ready", 32'(bus.o_sample_ready), 32'd1);
            chk("load_pvalid", 32'(bus.o_pair_valid), 32'd0);
            chk("load_done", 32'(bus.o_frame_done), (k == 0) ? 32'(exp_done_first) : 32'd0);
            @(posedge clk); #1;
            if (gap && k < N - 1) begin
                bus.i_sample_valid = 1'b0;
                bus.i_sample = $urandom;
                @(negedge clk);
                chk("gap_pvalid", 32'(bus.o_pair_valid), 32'd0);
                @(posedge clk); #1;
            end
        end
        bus.i_sample_valid = 1'b0;
    endtask

    task automatic drain(input pairs_t ea, input pairs_t eb, input int stall_at,
                         input int stall_len, input int npairs);
        for (int p = 0; p < npairs; p++) begin
            if (p == stall_at) begin
                bus.i_pair_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    bus.i_sample_valid = 1'b1;
                    bus.i_sample = $urandom;
                    @(negedge clk);
                    chk("stall_pvalid", 32'(bus.o_pair_valid), 32'd1);
                    chk("stall_ready", 32'(bus.o_sample_ready), 32'd0);
                    chk("stall_A", bus.o_A, ea[p]);
                    chk("stall_B", bus.o_B, eb[p]);
                    chk("stall_idx", 32'(bus.o_pair_idx), 32'(p));
                    @(posedge clk); #1;
                end
                bus.i_sample_valid = 1'b0;
            end
            bus.i_pair_ready = 1'b1;
            @(negedge clk);
            chk("pair_valid", 32'(bus.o_pair_valid), 32'd1);
            chk("pair_ready_lo", 32'(bus.o_sample_ready), 32'd0);
            chk("pair_A", bus.o_A, ea[p]);
            chk("pair_B", bus.o_B, eb[p]);
            chk("pair_idx", 32'(bus.o_pair_idx), 32'(p));
            chk("pair_done", 32'(bus.o_frame_done), 32'd0);
            @(posedge clk); #1;
        end
        bus.i_pair_ready = 1'b0;
        pending_done = (npairs == P);
    endtask

    task automatic make_frame(input logic [31:0] base, output frame_t xs);
        for (int k = 0; k < N; k++) xs[k] = base + 32'h0001_0001 * k;
    endtask

    task automatic run_frame(input frame_t xs, input bit gap, input int stall_at,
                             input int stall_len, input bit b2b,
                             input pairs_t ea, input pairs_t eb);
        if (pending_done && !b2b) begin
            @(negedge clk);
            chk("done_pulse", 32'(bus.o_frame_done), 32'd1);
            chk("done_ready", 32'(bus.o_sample_ready), 32'd1);
            @(posedge clk); #1;
            load_frame(xs, gap, 1'b0);
        end else begin
            load_frame(xs, gap, pending_done);
        end
        drain(ea, eb, stall_at, stall_len, P);
    endtask

    vec_t   tbl [4];
    frame_t xs;
    pairs_t ea, eb;

    initial begin
        build_order();
        tbl[0] = '{32'h0000_0000, 0, -1, 0, 0,
                   {32'h0003_0003, 32'h0001_0001, 32'h0002_0002, 32'h0000_0000},
                   {32'h0007_0007, 32'h0005_0005, 32'h0006_0006, 32'h0004_0004}};
        tbl[1] = '{32'h0000_0000, 1, -1, 0, 0,
                   {32'h0003_0003, 32'h0001_0001, 32'h0002_0002, 32'h0000_0000},
                   {32'h0007_0007, 32'h0005_0005, 32'h0006_0006, 32'h0004_0004}};
        tbl[2] = '{32'h0000_0000, 0, 2, 5, 0,
                   {32'h0003_0003, 32'h0001_0001, 32'h0002_0002, 32'h0000_0000},
                   {32'h0007_0007, 32'h0005_0005, 32'h0006_0006, 32'h0004_0004}};
        tbl[3] = '{32'h0010_0010, 0, -1, 0, 1,
                   {32'h0013_0013, 32'h0011_0011, 32'h0012_0012, 32'h0010_0010},
                   {32'h0017_0017, 32'h0015_0015, 32'h0016_0016, 32'h0014_0014}};

        rst_n = 1'b0;
        bus.i_sample = '0;
        bus.i_sample_valid = 1'b0;
        bus.i_pair_ready = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            make_frame(tbl[i].base, xs);
            run_frame(xs, tbl[i].gap, tbl[i].stall_at, tbl[i].stall_len,
                      tbl[i].b2b, tbl[i].exp_a, tbl[i].exp_b);
        end
        @(negedge clk);
        chk("last_done", 32'(bus.o_frame_done), 32'd1);
        @(posedge clk); #1;
        pending_done = 0;

        // Reset in the middle of a load: the partial frame must be discarded.
        for (int k = 0; k < 3; k++) begin
            bus.i_sample = 32'hdead_0000 + k;
            bus.i_sample_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.i_sample_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_load");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        make_frame(32'h0020_0020, xs);
        model(xs, ea, eb);
        run_frame(xs, 0, -1, 0, 0, ea, eb);

        // Reset in the middle of a drain: pairs stop at once, no done pulse.
        make_frame(32'h0030_0030, xs);
        model(xs, ea, eb);
        run_frame(xs, 0, -1, 0, 1, ea, eb);
        @(posedge clk); #1;
        make_frame(32'h0040_0040, xs);
        model(xs, ea, eb);
        load_frame(xs, 0, 0);
        drain(ea, eb, -1, 0, 2);
        chk("pre_rst_pvalid", 32'(bus.o_pair_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_drain");
        #1 rst_n = 1'b1;
        pending_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_drain_nodone", 32'(bus.o_frame_done), 32'd0);
            chk("rst_drain_pvalid", 32'(bus.o_pair_valid), 32'd0);
        end
        @(posedge clk); #1;
        make_frame(32'h0050_0050, xs);
        model(xs, ea, eb);
        run_frame(xs, 0, -1, 0, 0, ea, eb);

        // Random frames with random gaps, stalls and back-to-back starts.
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N; k++) xs[k] = $urandom;
            model(xs, ea, eb);
            run_frame(xs, 1'($urandom_range(0, 1)), int'($urandom_range(0, P - 1)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), ea, eb);
        end
        @(negedge clk);
        chk("final_done", 32'(bus.o_frame_done), 32'd1);
        @(negedge clk);
        chk("final_done_clear", 32'(bus.o_frame_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dft_input_reorder.md
# dft_input_reorder

Input-side buffer for the DFT network, directly upstream of the butterfly_sum stage. It collects one frame of N_POINTS complex samples through a valid/ready handshake and stores each sample at its bit-reversed address. It then emits the frame as N_POINTS/2 adjacent pairs (A, B), which are the operands of the first radix-2 decimation-in-time butterfly stage. Each pair carries an index that downstream logic uses for twiddle selection.

## Interface
Parameters:
- N_POINTS, 8: frame length. Must be a power of two, at least 4.
- LOG2_N, 3: log2(N_POINTS). Must be consistent with N_POINTS.
- WORD_SZ, 32: complex word width, packed {real[31:16], imag[15:0]}.

Ports:
- i_clk  input  1  clock. All logic is rising-edge.
- i_rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- i_sample  input  WORD_SZ  incoming complex sample.
- i_sample_valid  input  1  i_sample is valid this cycle.
- o_sample_ready  output  1  block accepts a sample this cycle.
- o_A  output  WORD_SZ  butterfly upper operand.
- o_B  output  WORD_SZ  butterfly lower operand.
- o_pair_idx  output  LOG2_N-1  index of the current pair, 0..N_POINTS/2-1.
- o_pair_valid  output  1  o_A, o_B and o_pair_idx are valid.
- i_pair_ready  input  1  downstream accepts the pair this cycle.
- o_frame_done  output  1  one-cycle pulse after the last pair of a frame is accepted.

## Operation
- Storage: N_POINTS x WORD_SZ register array, a write counter wr_cnt (LOG2_N bits) and a read counter rd_cnt (LOG2_N-1 bits).
- Two-state FSM: LOAD and DRAIN.
- LOAD:
  - o_sample_ready=1 and o_pair_valid=0.
  - A sample is accepted when i_sample_valid and o_sample_ready are both 1.
  - On accept, write buf[bitrev(wr_cnt)] <= i_sample, then wr_cnt++.
  - When the accepted sample has wr_cnt==N_POINTS-1: wr_cnt wraps to 0 and the FSM moves to DRAIN.
- DRAIN:
  - o_sample_ready=0 and o_pair_valid=1.
  - o_A=buf[2*rd_cnt], o_B=buf[2*rd_cnt+1], o_pair_idx=rd_cnt.
  - These outputs are combinational from the registers and stable until the pair is accepted.
  - A pair is accepted when o_pair_valid and i_pair_ready are both 1; on accept, rd_cnt++.
  - Accepting the pair with rd_cnt==N_POINTS/2-1: rd_cnt wraps to 0, the FSM returns to LOAD, and o_frame_done is registered high for the next cycle only.
- When o_pair_valid=0, o_A, o_B and o_pair_idx are driven to 0.
- Samples are stored unmodified. No arithmetic or width change.
- i_pair_ready is ignored in LOAD. i_sample_valid is ignored in DRAIN; the upstream must hold the sample.
- Backpressure: i_pair_ready held low in DRAIN stalls indefinitely with outputs frozen.
- Reset, at any time including mid-frame:
  - Asynchronously sets state=LOAD, wr_cnt=0, rd_cnt=0, o_frame_done=0.
  - Resulting outputs: o_sample_ready=1, o_pair_valid=0, o_A=o_B=0, o_pair_idx=0.
  - Buffer contents are not cleared. A partial frame is discarded, and the next frame starts at slot bitrev(0).

## Timing
- Sample accept: one per cycle at full rate, so a frame loads in N_POINTS cycles.
- Pair 0 is valid on the cycle after the edge that accepts the last sample.
- Pairs: one per cycle when i_pair_ready=1, so a frame drains in N_POINTS/2 cycles.
- o_frame_done is high on the cycle after the last pair's accept edge. o_sample_ready is 1 in that same cycle.
- Minimum frame period: N_POINTS + N_POINTS/2 cycles. There is no overlap of load and drain.
- No combinational path from i_sample_valid to o_sample_ready. The only combinational input-to-output paths are none; the outputs depend on state and registers only.

## Test plan
- Ordering: N_POINTS=8, samples x0..x7 = 32'h0000_0000 .. 32'h0007_0007, i_pair_ready=1.
  - Expect pairs (x0,x4), (x2,x6), (x1,x5), (x3,x7) with idx 0,1,2,3 on four consecutive cycles.
  - Pair 0 appears one cycle after the x7 accept.
  - o_frame_done pulses once.
- Sample gaps: i_sample_valid toggling 1,0,1,0 across a frame -> identical pair sequence; pairs start one cycle after the 8th accept.
- Backpressure: hold i_pair_ready=0 for 5 cycles at pair 2.
  - o_A=x1, o_B=x5 and o_pair_idx=2 stay stable.
  - o_sample_ready=0 throughout; samples offered in DRAIN are not consumed.
- Back-to-back frames: frame 2 samples 32'h0010_0010+k are offered immediately.
  - The first is accepted in the o_frame_done cycle.
  - Frame 2 pairs are correct with no frame-1 data leaking.
- Reset mid-load: assert i_rst_n=0 asynchronously after 3 samples, then release.
  - Outputs go to their reset values immediately.
  - A fresh 8-sample frame yields the correct pairs.
- Reset mid-drain: assert reset after pair 1 -> o_pair_valid drops to 0 immediately and no o_frame_done is produced; the next full frame drains normally.
